// File: rtl/sd_rdport_arbiter_if.sv
// Read-port bundle: SD engine (port 0), host/debug reader (port 1) and the backing-store port.
interface sd_rdport_arbiter_if #(
   parameter int unsigned AW = 32
);
   logic          r0_req;
   logic [AW-1:0] r0_addr;
   logic          r0_rvalid;
   logic [7:0]    r0_rdata;
   logic          r1_req;
   logic [AW-1:0] r1_addr;
   logic          r1_gnt;
   logic          r1_rvalid;
   logic [7:0]    r1_rdata;
   logic          r1_starved;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;

   // Arbiter side
   modport slave (
      input  r0_req, r0_addr, r1_req, r1_addr, mem_rdata,
      output r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata, r1_starved,
             mem_en, mem_addr
   );

   // Requesters and memory side
   modport master (
      output r0_req, r0_addr, r1_req, r1_addr, mem_rdata,
      input  r0_rvalid, r0_rdata, r1_gnt, r1_rvalid, r1_rdata, r1_starved,
             mem_en, mem_addr
   );
endinterface

// File: rtl/sd_rdport_arbiter.sv
// Shares one byte-wide backing-store read port between the SD data engine (port 0, priority)
// and a stallable host reader (port 1); returned data is steered back through a tag pipeline.
module sd_rdport_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned HOLD_GAP   = 4,
   parameter int unsigned STARVE_LIM = 1024
) (
   input  logic                 sdclk,
   input  logic                 rst_n,
   sd_rdport_arbiter_if.slave   port_if,
   output logic [1:0]           owner_o
);

   localparam int unsigned GAP_W  = 4;
   localparam int unsigned WAIT_W = $clog2(STARVE_LIM + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SD_OWN = 2'd1,
      HOST   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                issue_d, port_d, gnt_d;
   logic [AW-1:0]       addr_d;

   logic                mem_en_q, port_q, gnt_q, starved_q;
   logic [AW-1:0]       mem_addr_q;
   logic [MEM_LAT-1:0]  tag_v_q, tag_p_q;
   logic                r0_rvalid_q, r1_rvalid_q;
   logic [7:0]          r0_rdata_q, r1_rdata_q;
   logic                tag_v, tag_p;

   assign tag_v = tag_v_q[MEM_LAT-1];
   assign tag_p = tag_p_q[MEM_LAT-1];

   // Ownership FSM, issue selection and starvation counter
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      issue_d = 1'b0;
      port_d  = 1'b0;
      gnt_d   = 1'b0;
      addr_d  = mem_addr_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (port_if.r0_req) begin
               state_d = SD_OWN;
               issue_d = 1'b1;
               addr_d  = port_if.r0_addr;
               gap_d   = '0;
            end else if (port_if.r1_req && !gnt_q) begin
               state_d = HOST;
               issue_d = 1'b1;
               port_d  = 1'b1;
               addr_d  = port_if.r1_addr;
               gnt_d   = 1'b1;
            end
         end
         SD_OWN: begin
            if (port_if.r0_req) begin
               issue_d = 1'b1;
               addr_d  = port_if.r0_addr;
               gap_d   = '0;
            end else if (gap_q == GAP_W'(HOLD_GAP - 1)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         HOST: begin
            state_d = IDLE;
            if (port_if.r0_req) begin
               state_d = SD_OWN;
               issue_d = 1'b1;
               addr_d  = port_if.r0_addr;
               gap_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Requests seen while a grant is still showing are ignored, so they do not count as waiting
      if (gnt_d) begin
         wait_d = '0;
      end else if (port_if.r1_req && !gnt_q && (wait_q != WAIT_W'(STARVE_LIM))) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge sdclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gap_q       <= '0;
         wait_q      <= '0;
         gnt_q       <= 1'b0;
         starved_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         port_q      <= 1'b0;
         mem_addr_q  <= '0;
         tag_v_q     <= '0;
         tag_p_q     <= '0;
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         wait_q      <= wait_d;
         gnt_q       <= gnt_d;
         starved_q   <= (wait_q == WAIT_W'(STARVE_LIM));
         mem_en_q    <= issue_d;
         port_q      <= port_d;
         mem_addr_q  <= addr_d;
         // Tag enters alongside the memory strobe so it exits with the matching read data
         tag_v_q     <= MEM_LAT'({tag_v_q, mem_en_q});
         tag_p_q     <= MEM_LAT'({tag_p_q, port_q});
         r0_rvalid_q <= tag_v && !tag_p;
         r1_rvalid_q <= tag_v && tag_p;
         if (tag_v && !tag_p) r0_rdata_q <= port_if.mem_rdata;
         if (tag_v && tag_p)  r1_rdata_q <= port_if.mem_rdata;
      end
   end

   assign port_if.mem_en     = mem_en_q;
   assign port_if.mem_addr   = mem_addr_q;
   assign port_if.r0_rvalid  = r0_rvalid_q;
   assign port_if.r0_rdata   = r0_rdata_q;
   assign port_if.r1_gnt     = gnt_q;
   assign port_if.r1_rvalid  = r1_rvalid_q;
   assign port_if.r1_rdata   = r1_rdata_q;
   assign port_if.r1_starved = starved_q;
   assign owner_o            = state_q;

endmodule

// File: tb/tb_sd_rdport_arbiter.sv
// Directed bench for sd_rdport_arbiter: priority, hold-gap release, latency, data steering, starvation.
module tb_sd_rdport_arbiter;

   localparam int unsigned AW         = 32;
   localparam int unsigned MEM_LAT    = 2;
   localparam int unsigned HOLD_GAP   = 4;
   localparam int unsigned STARVE_LIM = 1024;
   localparam int          LAT        = 3;  // request edge to rvalid edge

   typedef struct {
      int         at;
      logic [7:0] data;
   } exp_t;

   logic       sdclk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] owner;
   int         cyc   = 0;
   int         total = 0;
   int         bad   = 0;
   exp_t       q0[$];
   exp_t       q1[$];
   logic [7:0] m0 = 8'h00;
   logic [7:0] m1 = 8'h00;

   sd_rdport_arbiter_if #(.AW(AW)) bus ();

   sd_rdport_arbiter #(
      .AW(AW), .MEM_LAT(MEM_LAT), .HOLD_GAP(HOLD_GAP), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .sdclk   (sdclk),
      .rst_n   (rst_n),
      .port_if (bus),
      .owner_o (owner)
   );

   always #5 sdclk = ~sdclk;
   always @(posedge sdclk) cyc++;

   // Memory model: returns addr[7:0], MEM_LAT edges after it samples the strobe
   always @(posedge sdclk) begin
      m0 <= bus.mem_en ? bus.mem_addr[7:0] : 8'hEE;
      m1 <= m0;
   end
   assign bus.mem_rdata = m1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({bus.r0_rvalid, bus.r0_rdata, bus.r1_gnt, bus.r1_rvalid, bus.r1_rdata,
                  bus.r1_starved, bus.mem_en, bus.mem_addr, owner});
   endfunction

   task automatic tick();
      @(posedge sdclk);
      #1;
   endtask

   task automatic r0_push(input logic [31:0] a);
      exp_t e;
      bus.r0_req  = 1'b1;
      bus.r0_addr = a;
      e.at   = cyc + 1;
      e.data = a[7:0];
      q0.push_back(e);
      tick();
   endtask

   task automatic push1(input int at, input logic [7:0] d);
      exp_t e;
      e.at   = at;
      e.data = d;
      q1.push_back(e);
   endtask

   task automatic r1_wait_gnt(input int budget, output int g);
      g = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (bus.r1_gnt) begin
            g = cyc;
            bus.r1_req = 1'b0;
            break;
         end
      end
      if (g < 0) begin
         chk("r1_gnt_timeout", 64'(bus.r1_gnt), 64'(1));
         bus.r1_req = 1'b0;
      end
   endtask

   // Return monitor: every rvalid must match the oldest outstanding request, on time
   always @(negedge sdclk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.r0_rvalid) begin
            chk("r0_expected", 64'(q0.size() != 0), 64'(1));
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("r0_lat", 64'(cyc), 64'(e.at + LAT));
               chk("r0_data", 64'(bus.r0_rdata), 64'(e.data));
            end
         end else if (q0.size() != 0 && cyc > q0[0].at + LAT) begin
            chk("r0_missing", 64'(cyc), 64'(q0[0].at + LAT));
            void'(q0.pop_front());
         end
         if (bus.r1_rvalid) begin
            chk("r1_expected", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) begin
               e = q1.pop_front();
               chk("r1_lat", 64'(cyc), 64'(e.at + LAT));
               chk("r1_data", 64'(bus.r1_rdata), 64'(e.data));
            end
         end else if (q1.size() != 0 && cyc > q1[0].at + LAT) begin
            chk("r1_missing", 64'(cyc), 64'(q1[0].at + LAT));
            void'(q1.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g, s, l;
      bus.r0_req  = 1'b0;
      bus.r0_addr = '0;
      bus.r1_req  = 1'b0;
      bus.r1_addr = '0;

      // Reset and idle
      repeat (3) @(posedge sdclk);
      #1 chk("rst_outs", outs(), 64'(0));
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outs", outs(), 64'(0));
      end

      // Reset during an in-flight r0 read drops it
      bus.r0_req  = 1'b1;
      bus.r0_addr = 32'h155;
      tick();
      bus.r0_req = 1'b0;
      chk("inflight_mem_en", 64'(bus.mem_en), 64'(1));
      chk("inflight_owner", 64'(owner), 64'(1));
      tick();
      rst_n = 1'b0;
      #1 chk("async_rst_owner", 64'(owner), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_rvalid_after_rst", 64'({bus.r0_rvalid, bus.r1_rvalid}), 64'(0));
      end

      // 512-request r0 burst, then hold-gap release
      chk("owner_pre_burst", 64'(owner), 64'(0));
      for (int i = 0; i < 512; i++) begin
         r0_push(32'h200 + 32'(i));
         chk("burst_owner", 64'(owner), 64'(1));
         chk("burst_addr", 64'(bus.mem_addr), 64'(32'h200 + 32'(i)));
      end
      bus.r0_req = 1'b0;
      tick();
      tick();
      tick();
      chk("hold_owner", 64'(owner), 64'(1));
      tick();
      chk("release_owner", 64'(owner), 64'(0));
      repeat (4) tick();
      chk("burst_drain", 64'(q0.size()), 64'(0));

      // Single r1 read while idle
      chk("r1_owner_pre", 64'(owner), 64'(0));
      bus.r1_req  = 1'b1;
      bus.r1_addr = 32'h1234;
      s = cyc + 1;
      r1_wait_gnt(8, g);
      chk("r1_gnt_edge", 64'(g), 64'(s));
      chk("r1_owner_host", 64'(owner), 64'(2));
      chk("r1_mem_addr", 64'(bus.mem_addr), 64'(32'h1234));
      push1(g, 8'h34);
      tick();
      chk("r1_gnt_pulse", 64'(bus.r1_gnt), 64'(0));
      chk("r1_owner_back", 64'(owner), 64'(0));
      repeat (4) tick();
      chk("r1_drain", 64'(q1.size()), 64'(0));

      // r1 held across an every-other-cycle r0 stream
      bus.r1_req  = 1'b1;
      bus.r1_addr = 32'h0ABC;
      for (int i = 0; i < 1024; i++) begin
         r0_push(32'h1000 + 32'(i));
         chk("alt_no_gnt_a", 64'(bus.r1_gnt), 64'(0));
         bus.r0_req = 1'b0;
         tick();
         chk("alt_no_gnt_b", 64'(bus.r1_gnt), 64'(0));
      end
      l = cyc - 1;
      r1_wait_gnt(16, g);
      chk("alt_gnt_edge", 64'(g), 64'(l + 1 + int'(HOLD_GAP)));
      push1(g, 8'hBC);
      repeat (6) tick();
      chk("alt_drain0", 64'(q0.size()), 64'(0));
      chk("alt_drain1", 64'(q1.size()), 64'(0));

      // r0 and r1 rise together in IDLE
      bus.r1_req  = 1'b1;
      bus.r1_addr = 32'h99;
      s = cyc + 1;
      r0_push(32'h77);
      bus.r0_req = 1'b0;
      chk("sim_owner", 64'(owner), 64'(1));
      chk("sim_mem_addr", 64'(bus.mem_addr), 64'(32'h77));
      chk("sim_no_gnt", 64'(bus.r1_gnt), 64'(0));
      r1_wait_gnt(16, g);
      chk("sim_gnt_edge", 64'(g), 64'(s + 1 + int'(HOLD_GAP)));
      chk("sim_r1_addr", 64'(bus.mem_addr), 64'(32'h99));
      push1(g, 8'h99);
      repeat (6) tick();

      // Starvation under continuous r0 traffic
      bus.r1_req  = 1'b1;
      bus.r1_addr = 32'h2468;
      s = cyc + 1;
      for (int i = 0; i < 1100; i++) begin
         r0_push(32'h4000 + 32'(i));
         chk("starve_flag", 64'(bus.r1_starved), 64'(i >= int'(STARVE_LIM)));
      end
      bus.r0_req = 1'b0;
      r1_wait_gnt(16, g);
      chk("starve_gnt_edge", 64'(g), 64'(s + 1099 + 1 + int'(HOLD_GAP)));
      chk("starve_at_gnt", 64'(bus.r1_starved), 64'(1));
      push1(g, 8'h68);
      tick();
      chk("starve_clear", 64'(bus.r1_starved), 64'(0));
      repeat (6) tick();
      chk("final_drain0", 64'(q0.size()), 64'(0));
      chk("final_drain1", 64'(q1.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
